receive: RTL and testbench
==========================

# receive

Serial-to-parallel receiver for the team's single-wire, MSB-first framed link: it deserialises the bit stream produced by our serial transmitter and presents each completed word on a valid/ready output. It sits at the line-input end of the link, between the `rxd` wire and the consuming logic. It also checks frame gaps and reports frame errors and overruns.

## Interface
- `WIDTH`, default 8: data bits per frame.
- `clk`  input  1: sole clock; `rxd` is sampled on every rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `rxd`  input  1: serial line; carries a synchronous, same-clock register output.
- `word`  output  WIDTH: received word, valid while `valid`=1.
- `valid`  output  1: `word` holds an unconsumed word.
- `ready`  input  1: consumer accepts `word` on an edge where `valid`&&`ready`.
- `frame_err`  output  1: one-cycle pulse when a gap sample is 1.
- `overrun`  output  1: one-cycle pulse when a good word is dropped.
- `err_count`  output  8: saturating count of frame errors plus overruns.

## Operation
- Line format: a repeating period of WIDTH+1 cycles, made of one gap cycle (line must be 0) followed by WIDTH data bits, MSB first. The transmitter drives 0 during its reset, so alignment is set by a common reset.
- States:
  - GAP: one sample. The next state is always DATA.
  - DATA: WIDTH samples, counted `bit_cnt` 0..WIDTH-1. After sample WIDTH-1 the next state is GAP.
- After reset the state is GAP. The first edge with `rst` low samples the gap.
- DATA shifts the register left with `rxd` entering at the LSB: `shreg <= {shreg[WIDTH-2:0], rxd}`.
- GAP sample at the end of a frame (every GAP except the first one after reset):
  - `rxd`=0: the frame is good and `shreg` is offered to the holding register.
  - `rxd`=1: `frame_err` pulses, the word is discarded and `err_count` increments. Alignment is kept (no hunt); only `rst` realigns.
- Holding register rules at a good-frame edge:
  - `valid`=0: load `word`; `valid` becomes 1.
  - `valid`=1 and `ready`=1: the old word is consumed and the new word is loaded; `valid` stays 1; no overrun.
  - `valid`=1 and `ready`=0: the new word is dropped and the old word is held. `overrun` pulses and `err_count` increments.
- `valid`&&`ready` with no good frame: `valid` becomes 0 next cycle; `word` keeps its value.
- `err_count` saturates at 255. Frame error and overrun cannot occur in the same cycle.
- Reset values: `word`=0, `valid`=0, `frame_err`=0, `overrun`=0, `err_count`=0, `shreg`=0, `bit_cnt`=0, state=GAP.
- Reset mid-frame discards any partial word and any held word.

## Timing
- Edge 1 after reset release samples the gap. Edges 2..WIDTH+1 sample data MSB..LSB. Edge WIDTH+2 samples the gap again.
- A word is visible with `valid`=1 after edge WIDTH+2, i.e. edge 10 for WIDTH=8. This gives 1 cycle of latency from the trailing gap sample.
- Frames repeat every WIDTH+1 cycles. Sustained throughput is one word per 9 cycles at the default width.
- `frame_err` and `overrun` are registered and high for exactly the cycle after the offending gap edge.
- `ready` is combinationally unused. All outputs are registered.

## Structure
- Package `receive_pkg`:
  - state enum `{ST_GAP, ST_DATA}`;
  - `RX_WIDTH_DEFAULT = 8`;
  - `ERR_CNT_W = 8`.
- Sub-module `rx_hold`: holding register with valid/ready, load, drop and overrun logic. `receive` instantiates it once.
- `receive` holds the FSM, bit counter, shift register, gap check and error counter.

## Test plan
- After reset, send 0xA5 as gap 0 then bits 1,0,1,0,0,1,0,1 then gap 0, with `ready`=1. Expect `word`=0xA5 and `valid`=1 after edge 10, consumed the following edge, and no error pulses.
- Send back-to-back 0x3C and 0xFF with `ready` held at 0. Expect `word` to stay 0x3C, one `overrun` pulse at the second frame's gap, and `err_count`=1.
- Hold `valid`=1 with 0x01 and raise `ready` exactly on the gap edge of a good frame 0x80. Expect `word`=0x80, `valid` staying 1, and no overrun.
- Drive the gap sample of frame 0x55 as 1. Expect a `frame_err` pulse, `valid` staying 0 and `err_count`=1. The next frame 0x0F is received correctly.
- Assert `rst` at data bit 4 of a frame while `valid`=1. Expect all outputs to be 0 next cycle. The frame 0xC3 sent after release is received after edge 10.
- Force 260 consecutive bad gaps. Expect `err_count` to saturate at 255.

Source files
------------

// File: rtl/receive_pkg.sv
// Shared types and sizing constants for the framed serial receiver.
package receive_pkg;

  typedef enum logic {ST_GAP, ST_DATA} rx_state_e;

  localparam int RX_WIDTH_DEFAULT = 8;
  localparam int ERR_CNT_W        = 8;

endpackage

// File: rtl/rx_hold.sv
// Output holding register: parks a received word until the consumer takes it,
// and drops a new word (flagging overrun) if the old one is still unconsumed.
module rx_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             overrun,
  output logic             drop
);

  logic take;

  // A consumed word frees the slot on the same edge, so load and consume can coincide.
  assign take = load && (!valid || ready);
  assign drop = load && valid && !ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      word    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= drop;
      if (take) begin
        word  <= din;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/receive.sv
// Serial-to-parallel receiver for the MSB-first framed link: one gap bit (0)
// followed by WIDTH data bits, alignment fixed by the shared reset.
module receive
  import receive_pkg::*;
#(
  parameter int WIDTH = RX_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [WIDTH-1:0]     word,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rx_state_e        state;
  rx_state_e        state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             armed;
  logic             last_bit;
  logic             gap_edge;
  logic             data_edge;
  logic             frame_good;
  logic             frame_bad;
  logic             drop;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_GAP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_GAP:  state_nxt = ST_DATA;
      ST_DATA: if (last_bit) state_nxt = ST_GAP;
      default: state_nxt = ST_GAP;
    endcase
  end

  // The first gap after reset only establishes alignment; it closes no frame.
  always_comb begin
    gap_edge   = (state == ST_GAP);
    data_edge  = (state == ST_DATA);
    frame_good = gap_edge && armed && !rxd;
    frame_bad  = gap_edge && armed && rxd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      armed     <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= frame_bad;
      if (gap_edge) armed <= 1'b1;
      if (data_edge) begin
        shreg   <= {shreg[WIDTH-2:0], rxd};
        bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      end
      if (frame_bad || drop) err_count <= sat_inc(err_count);
    end
  end

  rx_hold #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (frame_good),
    .din     (shreg),
    .ready   (ready),
    .word    (word),
    .valid   (valid),
    .overrun (overrun),
    .drop    (drop)
  );

endmodule

// File: tb/tb_receive.sv
// Randomized and directed bench for receive, checked every cycle against a
// frame-level reference model of the link protocol.
module tb_receive;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rxd = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] word;
  logic         valid;
  logic         frame_err;
  logic         overrun;
  logic [7:0]   err_count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_word, m_valid, m_fe, m_ov, m_err;
  int m_acc, m_phase, m_first;

  receive #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .word      (word),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the link rules for one edge: phase 0 is the gap, 1..W are data bits.
  task automatic model_edge(input int r, input int rdy, input int in_rst);
    int good, bad, frame_val;
    good = 0;
    bad  = 0;
    frame_val = 0;
    if (in_rst != 0) begin
      m_word = 0; m_valid = 0; m_fe = 0; m_ov = 0; m_err = 0;
      m_acc = 0; m_phase = 0; m_first = 1;
      return;
    end
    if (m_phase == 0) begin
      if (m_first == 0) begin
        if (r != 0) bad = 1;
        else        good = 1;
      end
      frame_val = m_acc;
      m_first = 0;
      m_acc = 0;
      m_phase = 1;
    end else begin
      m_acc = (m_acc * 2 + r) % (1 << W);
      m_phase = (m_phase == W) ? 0 : m_phase + 1;
    end
    m_fe = bad;
    m_ov = (good != 0 && m_valid != 0 && rdy == 0) ? 1 : 0;
    if (good != 0 && (m_valid == 0 || rdy != 0)) begin
      m_word = frame_val;
      m_valid = 1;
    end else if (m_valid != 0 && rdy != 0) begin
      m_valid = 0;
    end
    if ((bad != 0 || m_ov != 0) && m_err < 255) m_err++;
  endtask

  task automatic step(input logic r, input logic rdy);
    rxd = r;
    ready = rdy;
    @(posedge clk);
    model_edge(int'(r), int'(rdy), int'(rst));
    #1;
    chk("word", 32'(word), 32'(m_word));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("frame_err", 32'(frame_err), 32'(m_fe));
    chk("overrun", 32'(overrun), 32'(m_ov));
    chk("err_count", 32'(err_count), 32'(m_err));
  endtask

  function automatic logic pick(input int code);
    if (code == 2) return 1'($urandom_range(0, 1));
    return (code != 0);
  endfunction

  // Gap bit first, then W data bits MSB first.
  task automatic send(input logic [W-1:0] d, input logic gap, input int rdy_gap, input int rdy_data);
    step(gap, pick(rdy_gap));
    for (int i = W - 1; i >= 0; i--) step(d[i], pick(rdy_data));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    model_edge(0, 0, 1);
    do_reset();

    // single word, consumer always ready
    send(8'hA5, 1'b0, 1, 1);
    chk("a5_pre_gap_valid", 32'(valid), 32'd0);
    step(1'b0, 1'b1);
    chk("a5_word", 32'(word), 32'hA5);
    chk("a5_valid", 32'(valid), 32'd1);
    step(1'b0, 1'b1);
    chk("a5_consumed", 32'(valid), 32'd0);

    // overrun with ready held low
    do_reset();
    send(8'h3C, 1'b0, 0, 0);
    send(8'hFF, 1'b0, 0, 0);
    step(1'b0, 1'b0);
    chk("ovr_pulse", 32'(overrun), 32'd1);
    chk("ovr_word", 32'(word), 32'h3C);
    chk("ovr_count", 32'(err_count), 32'd1);
    for (int i = 0; i < W; i++) step(1'b0, 1'b0);

    // consume and reload on the same gap edge
    do_reset();
    send(8'h01, 1'b0, 0, 0);
    send(8'h80, 1'b0, 0, 0);
    step(1'b0, 1'b1);
    chk("swap_word", 32'(word), 32'h80);
    chk("swap_valid", 32'(valid), 32'd1);
    chk("swap_no_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < W; i++) step(1'b0, 1'b0);

    // bad gap discards 0x55, next frame 0x0F is good
    do_reset();
    send(8'h55, 1'b0, 1, 1);
    send(8'h0F, 1'b1, 1, 1);
    chk("fe_count", 32'(err_count), 32'd1);
    chk("fe_valid", 32'(valid), 32'd0);
    step(1'b0, 1'b0);
    chk("fe_next_word", 32'(word), 32'h0F);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1);

    // reset mid-frame while a word is held
    do_reset();
    send(8'hAA, 1'b0, 0, 0);
    send(8'h66, 1'b0, 0, 0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_word", 32'(word), 32'd0);
    rst = 1'b0;
    send(8'hC3, 1'b0, 0, 0);
    step(1'b0, 1'b0);
    chk("after_rst_word", 32'(word), 32'hC3);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1);

    // error counter saturation
    do_reset();
    send(8'($urandom), 1'b0, 2, 2);
    for (int k = 0; k < 260; k++) send(8'($urandom), 1'b1, 2, 2);
    step(1'b0, 1'b1);
    chk("err_sat", 32'(err_count), 32'd255);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1);

    // random traffic
    do_reset();
    for (int k = 0; k < 200; k++)
      send(8'($urandom), ($urandom_range(0, 9) == 0), 2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
